// File: rtl/ysyx_22041071_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_mem_arbiter
//
// Shares one single-ported doubleword memory between the instruction fetch
// port (IF) and the load/store data port (D). Exactly one transaction is in
// flight at a time and moves through IDLE -> ACCESS -> RESP.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. A requester holds valid (and its payload) until it sees
// ready. Request readies are driven combinationally in IDLE, and only the
// winner's ready is high. Response valid/data stay stable until the consumer
// raises ready.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   if_req_*          fetch request (valid/ready/addr)
//   if_flush          fetch redirect, cancels the fetch transaction
//   if_rsp_*          fetch response (valid/ready/data)
//   d_req_*           data request (valid/ready/wen/addr/wdata/wmask)
//   d_rsp_*           data response (valid/ready/data; 0 for stores)
//   mem_*             memory port; mem_rdata valid the cycle after mem_en
//   dbg_state_o       current FSM state
//   dbg_starve_cnt_o  consecutive data grants while fetch waited
//   dbg_owner_o       owner of the current transaction (0 = IF, 1 = D)
// ---------------------------------------------------------------------------
module ysyx_22041071_mem_arbiter #(
  parameter logic [63:0] START_ADDR = 64'h8000_0000,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [63:0] if_rsp_data,
  // data port
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_wen,
  input  logic [63:0] d_req_addr,
  input  logic [63:0] d_req_wdata,
  input  logic [7:0]  d_req_wmask,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [63:0] d_rsp_data,
  // memory port
  output logic        mem_en,
  output logic        mem_wen,
  output logic [63:0] mem_ridx,
  output logic [63:0] mem_widx,
  output logic [63:0] mem_wdata,
  output logic [63:0] mem_wmask,
  input  logic [63:0] mem_rdata,
  // debug
  output logic [1:0]  dbg_state_o,
  output logic [1:0]  dbg_starve_cnt_o,
  output logic        dbg_owner_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  // starve counter is two bits wide, so the limit is taken modulo 4
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  state_t      state_q;
  logic        owner_q;
  logic [1:0]  starve_q;
  logic        wen_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic        if_rsp_valid_q;
  logic        d_rsp_valid_q;
  logic [63:0] if_rsp_data_q;
  logic [63:0] d_rsp_data_q;
  logic        first_q;   // high during the first RESP cycle only

  logic        fetch_ok;
  logic        grant_if;
  logic        grant_d;
  logic        mem_active;
  logic [63:0] resp_rdata;
  logic [63:0] wmask_bits;

  // -------------------------------------------------------------------------
  // Arbitration: data wins by default; fetch wins once the data side has
  // been granted STARVE_MAX times in a row while fetch was waiting. A flush
  // blocks the fetch request but leaves the data side free to win.
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_ok = if_req_valid && !if_flush;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == S_IDLE && !reset) begin
      if (fetch_ok && starve_q == STARVE_LIM) begin
        grant_if = 1'b1;
      end else if (d_req_valid) begin
        grant_d = 1'b1;
      end else if (fetch_ok) begin
        grant_if = 1'b1;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  // -------------------------------------------------------------------------
  // Memory port: only driven during the single ACCESS cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    wmask_bits = '0;
    for (int i = 0; i < 8; i++) begin
      wmask_bits[8*i +: 8] = {8{wmask_q[i]}};
    end
  end

  assign mem_active = (state_q == S_ACCESS);
  assign mem_en     = mem_active;
  assign mem_wen    = mem_active & wen_q;
  assign mem_ridx   = mem_active ? ((addr_q - START_ADDR) >> 3) : 64'd0;
  assign mem_widx   = mem_ridx;
  assign mem_wdata  = mem_active ? wdata_q : 64'd0;
  assign mem_wmask  = mem_active ? wmask_bits : 64'd0;

  // -------------------------------------------------------------------------
  // Response data. mem_rdata only becomes valid in the first RESP cycle, so
  // that cycle forwards it directly while it is captured; afterwards the
  // captured copy is presented, keeping the data stable across stalls.
  // -------------------------------------------------------------------------
  assign resp_rdata  = wen_q ? 64'd0 : mem_rdata;
  assign if_rsp_data = (first_q && owner_q == OWN_IF) ? resp_rdata : if_rsp_data_q;
  assign d_rsp_data  = (first_q && owner_q == OWN_D)  ? resp_rdata : d_rsp_data_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign d_rsp_valid  = d_rsp_valid_q;

  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_q;
  assign dbg_owner_o      = owner_q;

  // -------------------------------------------------------------------------
  // Transaction FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      owner_q        <= OWN_IF;
      starve_q       <= 2'd0;
      wen_q          <= 1'b0;
      addr_q         <= START_ADDR;
      wdata_q        <= 64'd0;
      wmask_q        <= 8'd0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if_rsp_data_q  <= 64'd0;
      d_rsp_data_q   <= 64'd0;
      first_q        <= 1'b0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_if) begin
            owner_q  <= OWN_IF;
            addr_q   <= if_req_addr;
            wen_q    <= 1'b0;
            wdata_q  <= 64'd0;
            wmask_q  <= 8'd0;
            starve_q <= 2'd0;
            state_q  <= S_ACCESS;
          end else if (grant_d) begin
            owner_q <= OWN_D;
            addr_q  <= d_req_addr;
            wen_q   <= d_req_wen;
            wdata_q <= d_req_wdata;
            wmask_q <= d_req_wmask;
            state_q <= S_ACCESS;
            if (!if_req_valid) begin
              starve_q <= 2'd0;
            end else if (starve_q != STARVE_LIM) begin
              starve_q <= starve_q + 2'd1;
            end
          end else if (!if_req_valid) begin
            starve_q <= 2'd0;
          end
        end

        S_ACCESS: begin
          // a flushed fetch still completes its memory cycle but never responds
          if (owner_q == OWN_IF && if_flush) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_RESP;
            first_q <= 1'b1;
            if (owner_q == OWN_IF) begin
              if_rsp_valid_q <= 1'b1;
            end else begin
              d_rsp_valid_q <= 1'b1;
            end
          end
        end

        S_RESP: begin
          if (first_q) begin
            if (owner_q == OWN_IF) begin
              if_rsp_data_q <= resp_rdata;
            end else begin
              d_rsp_data_q <= resp_rdata;
            end
          end
          if (owner_q == OWN_IF) begin
            if (if_rsp_ready || if_flush) begin
              if_rsp_valid_q <= 1'b0;
              state_q        <= S_IDLE;
            end
          end else if (d_rsp_ready) begin
            d_rsp_valid_q <= 1'b0;
            state_q       <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
